uart_tx_ctrl: RTL and testbench

//   Sequencer for the UART transmit bit-select mux. Accepts one byte per

---
 rtl/uart_tx_ctrl.sv | 93 +++++++++
 tb/tb_uart_tx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches one byte per handshake and steps the bit-select
// mux through start, eight data bits and the stop bit(s), one bit time per step.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [3:0] sel,
  output logic [7:0] data_q,
  output logic       start_bit,
  output logic       end_bit
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             stop_cnt;
  logic             bit_end;

  assign bit_end   = (cnt == CNT_MAX);
  assign tx_ready  = (state == IDLE);
  assign start_bit = 1'b0;
  assign end_bit   = 1'b1;

  // Frame sequencer; sel always holds 0..9 so the mux default is unreachable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 4'd9;
      data_q   <= 8'h00;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      cnt      <= '0;
      stop_cnt <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_valid) begin
          data_q   <= tx_data;
          state    <= START;
          sel      <= 4'd0;
          cnt      <= '0;
          stop_cnt <= 1'b0;
          tx_busy  <= 1'b1;
        end
      end else if (!bit_end) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            sel   <= 4'd1;
          end
          DATA: begin
            if (sel == 4'd8) begin
              state <= STOP;
              sel   <= 4'd9;
            end else begin
              sel <= sel + 4'd1;
            end
          end
          STOP: begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              state    <= IDLE;
              stop_cnt <= 1'b0;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            sel   <= 4'd9;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table of bytes with hand-derived line patterns checked
// cycle by cycle through an expectation queue, plus back-to-back, reset and parameter corners.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance: CLKS_PER_BIT=4, STOP_BITS=1
  logic       valid0 = 1'b0;
  logic [7:0] data0  = 8'h00;
  logic       ready0, busy0, done0, sb0, eb0;
  logic [3:0] sel0;
  logic [7:0] dq0;

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid0), .tx_data(data0),
    .tx_ready(ready0), .tx_busy(busy0), .tx_done(done0), .sel(sel0),
    .data_q(dq0), .start_bit(sb0), .end_bit(eb0));

  // two stop bits
  logic       valid1 = 1'b0;
  logic [7:0] data1  = 8'h00;
  logic       ready1, busy1, done1, sb1, eb1;
  logic [3:0] sel1;
  logic [7:0] dq1;

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid1), .tx_data(data1),
    .tx_ready(ready1), .tx_busy(busy1), .tx_done(done1), .sel(sel1),
    .data_q(dq1), .start_bit(sb1), .end_bit(eb1));

  // minimum bit time
  logic       valid2 = 1'b0;
  logic [7:0] data2  = 8'h00;
  logic       ready2, busy2, done2, sb2, eb2;
  logic [3:0] sel2;
  logic [7:0] dq2;

  uart_tx_ctrl #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid2), .tx_data(data2),
    .tx_ready(ready2), .tx_busy(busy2), .tx_done(done2), .sel(sel2),
    .data_q(dq2), .start_bit(sb2), .end_bit(eb2));

  typedef struct {
    logic [3:0] sel;
    logic       line;
    logic [7:0] dq;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit   [0:9] line;   // index 0 = start bit, 9 = stop bit
    bit         hold;   // keep tx_valid high and corrupt tx_data mid-frame
  } vec_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic mux_line(input logic [3:0] s, input logic [7:0] d);
    if (s == 4'd0) return 1'b0;
    if (s <= 4'd8) return d[3'(s - 4'd1)];
    return 1'b1;
  endfunction

  task automatic push_frame(input logic [7:0] d, input bit [0:9] line);
    exp_t e;
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 4; k++) begin
        e.sel = 4'(b); e.line = line[b]; e.dq = d; e.busy = 1'b1; e.done = 1'b0;
        q.push_back(e);
      end
    e.sel = 4'd9; e.line = 1'b1; e.dq = d; e.busy = 1'b0; e.done = 1'b1;
    q.push_back(e);
  endtask

  // wait to the next falling edge and compare u0 against the head of the queue
  task automatic drain_one();
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      chk("queue_underflow", 1, 0);
      return;
    end
    e = q.pop_front();
    chk("sel",   int'(sel0), int'(e.sel));
    chk("line",  int'(mux_line(sel0, dq0)), int'(e.line));
    chk("data_q", int'(dq0), int'(e.dq));
    chk("busy",  int'(busy0), int'(e.busy));
    chk("ready", int'(ready0), int'(!e.busy));
    chk("done",  int'(done0), int'(e.done));
  endtask

  vec_t vecs[4];
  int   cyc, nine_cnt;
  bit   seen;

  initial begin
    vecs[0] = '{data: 8'hA5, line: 10'b0101001011, hold: 1'b0};
    vecs[1] = '{data: 8'h81, line: 10'b0100000011, hold: 1'b1};
    vecs[2] = '{data: 8'h00, line: 10'b0000000001, hold: 1'b0};
    vecs[3] = '{data: 8'hFF, line: 10'b0111111111, hold: 1'b0};

    // reset state
    #12;
    chk("rst_sel", int'(sel0), 9);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ready", int'(ready0), 1);
    chk("rst_done", int'(done0), 0);
    chk("rst_dq", int'(dq0), 0);
    chk("start_bit", int'(sb0), 0);
    chk("end_bit", int'(eb0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table of single frames
    foreach (vecs[v]) begin
      chk("ready_before_accept", int'(ready0), 1);
      valid0 = 1'b1;
      data0  = vecs[v].data;
      push_frame(vecs[v].data, vecs[v].line);
      for (int i = 0; i < 41; i++) begin
        drain_one();
        if (!vecs[v].hold && i == 0) valid0 = 1'b0;
        if (vecs[v].hold && i == 5) data0 = 8'h00;
        if (vecs[v].hold && i == 38) valid0 = 1'b0;
      end
    end

    // back-to-back with tx_valid held: second accept in the tx_done cycle
    @(negedge clk);
    valid0 = 1'b1;
    data0  = 8'h3C;
    push_frame(8'h3C, 10'b0001111001);
    push_frame(8'hFF, 10'b0111111111);
    for (int i = 0; i < 82; i++) begin
      drain_one();
      if (i == 0) data0 = 8'hFF;
      if (i == 41) valid0 = 1'b0;
    end

    // reset mid-frame takes effect without a clock edge
    @(negedge clk);
    valid0 = 1'b1;
    data0  = 8'h55;
    @(negedge clk);
    valid0 = 1'b0;
    repeat (9) @(negedge clk);
    chk("midframe_busy", int'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel", int'(sel0), 9);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_ready", int'(ready0), 1);
    chk("midrst_done", int'(done0), 0);
    @(negedge clk);
    chk("midrst_done_later", int'(done0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // two stop bits: 8 cycles of sel=9, tx_done 44 cycles after accept
    valid1 = 1'b1;
    data1  = 8'h00;
    cyc = 0; nine_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      valid1 = 1'b0;
      if (done1) seen = 1'b1;
      else begin
        chk("stop2_sel", int'(sel1), (cyc / 4 > 9) ? 9 : cyc / 4);
        if (sel1 == 4'd9) nine_cnt++;
        cyc++;
      end
    end
    chk("stop2_done_seen", int'(seen), 1);
    chk("stop2_frame_len", cyc, 44);
    chk("stop2_nine_cycles", nine_cnt, 8);

    // minimum bit time: 2 cycles per bit, tx_done at 20
    @(negedge clk);
    valid2 = 1'b1;
    data2  = 8'hA5;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      valid2 = 1'b0;
      if (done2) seen = 1'b1;
      else begin
        chk("cpb2_sel", int'(sel2), cyc / 2);
        cyc++;
      end
    end
    chk("cpb2_done_seen", int'(seen), 1);
    chk("cpb2_frame_len", cyc, 20);
    chk("cpb2_dq", int'(dq2), 8'hA5);

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
